// File: rtl/alu_muldiv_if.sv
// Execute-stage request/response bundle for the iterative mul/div unit.
// The pipeline side is the master; the unit is the slave.
interface alu_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             StartE;
    logic             FlushE;
    logic [2:0]       MulDivOpE;
    logic [WIDTH-1:0] Op1E;
    logic [WIDTH-1:0] Op2E;
    logic             ReadyE;
    logic             BusyE;
    logic             DoneE;
    logic [WIDTH-1:0] ResultE;
    logic [1:0]       MulDivFlags;

    modport master (
        output StartE, FlushE, MulDivOpE, Op1E, Op2E,
        input  ReadyE, BusyE, DoneE, ResultE, MulDivFlags
    );

    modport slave (
        input  StartE, FlushE, MulDivOpE, Op1E, Op2E,
        output ReadyE, BusyE, DoneE, ResultE, MulDivFlags
    );
endinterface

// File: rtl/alu_muldiv.sv
// Radix-2 iterative multiply/divide unit beside the execute-stage ALU.
// Fixed WIDTH+2 cycle latency for every op, start/done handshake.
module alu_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        reset,
    alu_muldiv_if.slave bus
);
    localparam int LATENCY     = WIDTH + 2;
    localparam int CALC_CYCLES = LATENCY - 2;
    localparam int CW          = $clog2(CALC_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic ready;
    logic busy;
    logic done;
    logic accept;

    logic [CW-1:0]      cnt;
    logic [2:0]         op_q;
    logic [WIDTH-1:0]   opd_q;
    logic [WIDTH-1:0]   a_raw_q;
    logic [WIDTH-1:0]   res_q;
    logic [1:0]         flags_q;
    logic [2*WIDTH-1:0] acc;
    logic               neg_q;
    logic               div0_q;

    logic             sgn_a;
    logic             sgn_b;
    logic             sa;
    logic             sb;
    logic             neg_in;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_part;
    logic               div_ge;
    logic [WIDTH-1:0]   div_rem;
    logic [2*WIDTH-1:0] acc_step;

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   fix_res;

    assign accept = bus.StartE && ready && !bus.FlushE;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (bus.FlushE) begin
            state_next = IDLE;
        end else begin
            unique case (state)
                IDLE: state_next = accept ? CALC : IDLE;
                CALC: state_next = (cnt == '0) ? FIX : CALC;
                FIX:  state_next = DONE;
                DONE: state_next = accept ? CALC : IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        ready = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        unique case (state)
            IDLE: ready = 1'b1;
            CALC: busy  = 1'b1;
            FIX:  busy  = 1'b1;
            DONE: begin
                ready = 1'b1;
                done  = 1'b1;
            end
            default: ;
        endcase
    end

    // Signed operands are reduced to magnitudes; the most-negative value
    // maps onto 2^(WIDTH-1), which is still exact as an unsigned number.
    always_comb begin
        sgn_a = 1'b0;
        sgn_b = 1'b0;
        unique case (bus.MulDivOpE)
            3'b001, 3'b100, 3'b110: begin
                sgn_a = 1'b1;
                sgn_b = 1'b1;
            end
            3'b010:  sgn_a = 1'b1;
            default: ;
        endcase
        sa     = sgn_a & bus.Op1E[WIDTH-1];
        sb     = sgn_b & bus.Op2E[WIDTH-1];
        mag_a  = sa ? -bus.Op1E : bus.Op1E;
        mag_b  = sb ? -bus.Op2E : bus.Op2E;
        neg_in = (bus.MulDivOpE[2] & bus.MulDivOpE[1]) ? sa : (sa ^ sb);
    end

    // acc holds {partial product, multiplier} or {remainder, quotient}.
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]}
                 + (acc[0] ? {1'b0, opd_q} : '0);
        div_part = acc[2*WIDTH-1:WIDTH-1];
        div_ge   = div_part >= {1'b0, opd_q};
        div_rem  = div_ge ? WIDTH'(div_part - {1'b0, opd_q})
                          : div_part[WIDTH-1:0];
        acc_step = op_q[2] ? {div_rem, acc[WIDTH-2:0], div_ge}
                           : {mul_sum, acc[WIDTH-1:1]};
    end

    always_comb begin
        prod_fix = neg_q ? -acc : acc;
        quo_fix  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix  = neg_q ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        fix_res  = '0;
        unique case (1'b1)
            op_q == 3'b000:
                fix_res = prod_fix[WIDTH-1:0];
            !op_q[2] && op_q[1:0] != 2'b00:
                fix_res = prod_fix[2*WIDTH-1:WIDTH];
            op_q[2] && !op_q[1]:
                fix_res = div0_q ? '1 : quo_fix;
            op_q[2] && op_q[1]:
                fix_res = div0_q ? a_raw_q : rem_fix;
            default: fix_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            op_q    <= '0;
            opd_q   <= '0;
            a_raw_q <= '0;
            acc     <= '0;
            neg_q   <= 1'b0;
            div0_q  <= 1'b0;
            res_q   <= '0;
            flags_q <= '0;
        end else begin
            if (accept) begin
                cnt     <= CW'(CALC_CYCLES - 1);
                op_q    <= bus.MulDivOpE;
                a_raw_q <= bus.Op1E;
                neg_q   <= neg_in;
                div0_q  <= (bus.Op2E == '0);
                opd_q   <= bus.MulDivOpE[2] ? mag_b : mag_a;
                acc     <= {{WIDTH{1'b0}},
                            (bus.MulDivOpE[2] ? mag_a : mag_b)};
            end else if (state == CALC) begin
                acc <= acc_step;
                if (cnt != '0) begin
                    cnt <= cnt - 1'b1;
                end
            end
            if (state == FIX && !bus.FlushE) begin
                res_q   <= fix_res;
                flags_q <= {fix_res[WIDTH-1], fix_res == '0};
            end
        end
    end

    assign bus.ReadyE      = ready;
    assign bus.BusyE       = busy;
    assign bus.DoneE       = done;
    assign bus.ResultE     = res_q;
    assign bus.MulDivFlags = flags_q;
endmodule

// File: tb/tb_alu_muldiv.sv
// Scoreboard bench for alu_muldiv: driver queues expectations,
// a negedge monitor pops and compares on every DoneE.
module tb_alu_muldiv;
    localparam int W   = 32;
    localparam int LAT = W + 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    alu_muldiv_if #(.WIDTH(32)) m32 ();
    alu_muldiv_if #(.WIDTH(8))  m8 ();

    alu_muldiv #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(m32));
    alu_muldiv #(.WIDTH(8))  dut8 (.clk(clk), .reset(reset), .bus(m8));

    typedef struct {
        logic [31:0] res;
        int          due;
    } exp_t;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
    } vec_t;

    exp_t        sbq[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic [31:0] last_res = '0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (!reset && m32.DoneE === 1'b1) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got DoneE=1 want none at cyc %0d", cyc);
            end else begin
                e = sbq.pop_front();
                chk("result", 64'(m32.ResultE), 64'(e.res));
                chk("flags", 64'(m32.MulDivFlags), {62'b0, e.res[31], e.res == 32'h0});
                chk("latency", 64'(cyc), 64'(e.due));
                last_res = e.res;
            end
        end
    end

    function automatic logic [31:0] ref32(logic [2:0] op, logic [31:0] a, logic [31:0] b);
        int          sa;
        int          sb;
        longint      p;
        logic [63:0] up;
        logic        ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'd0: begin
                up = {32'b0, a} * {32'b0, b};
                return up[31:0];
            end
            3'd1: begin
                p = longint'(sa) * longint'(sb);
                return p[63:32];
            end
            3'd2: begin
                p = longint'(sa) * longint'({32'b0, b});
                return p[63:32];
            end
            3'd3: begin
                up = {32'b0, a} * {32'b0, b};
                return up[63:32];
            end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                return sa / sb;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                return sa % sb;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic issue(logic [2:0] op, logic [31:0] a, logic [31:0] b,
                         logic [31:0] r, bit push);
        chk("ready_at_issue", 64'(m32.ReadyE), 64'd1);
        m32.MulDivOpE = op;
        m32.Op1E      = a;
        m32.Op2E      = b;
        m32.StartE    = 1'b1;
        if (push) sbq.push_back('{r, cyc + LAT});
        step();
        m32.StartE    = 1'b0;
        m32.MulDivOpE = 3'($urandom);
        m32.Op1E      = $urandom;
        m32.Op2E      = $urandom;
    endtask

    task automatic wait_done();
        for (int i = 0; i < LAT + 20; i++) begin
            if (m32.DoneE === 1'b1) return;
            step();
        end
        total++;
        bad++;
        $display("FAIL done_timeout: got no DoneE want DoneE within %0d cycles", LAT + 20);
    endtask

    task automatic run8(logic [2:0] op, logic [7:0] a, logic [7:0] b, logic [7:0] r);
        int n0;
        m8.MulDivOpE = op;
        m8.Op1E      = a;
        m8.Op2E      = b;
        m8.StartE    = 1'b1;
        n0           = cyc;
        step();
        m8.StartE    = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (m8.DoneE === 1'b1) break;
            step();
        end
        chk("w8_result", 64'(m8.ResultE), 64'(r));
        chk("w8_flags", 64'(m8.MulDivFlags), {62'b0, r[7], r == 8'h0});
        chk("w8_latency", 64'(cyc - n0), 64'd10);
        step();
    endtask

    vec_t dir [14];

    initial begin
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;

        dir = '{
            '{3'd0, 32'h0000_1234, 32'h0000_5678, 32'h0626_0060},
            '{3'd1, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF},
            '{3'd3, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001},
            '{3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF},
            '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD},
            '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF},
            '{3'd5, 32'h0000_0007, 32'h0000_0002, 32'h0000_0003},
            '{3'd7, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001},
            '{3'd4, 32'h0000_1234, 32'h0000_0000, 32'hFFFF_FFFF},
            '{3'd7, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234},
            '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000},
            '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000},
            '{3'd5, 32'h0000_1234, 32'h0000_0000, 32'hFFFF_FFFF},
            '{3'd6, 32'hFFFF_FF00, 32'h0000_0000, 32'hFFFF_FF00}
        };

        m32.StartE = 1'b0; m32.FlushE = 1'b0; m32.MulDivOpE = '0;
        m32.Op1E = '0; m32.Op2E = '0;
        m8.StartE = 1'b0; m8.FlushE = 1'b0; m8.MulDivOpE = '0;
        m8.Op1E = '0; m8.Op2E = '0;

        repeat (3) step();
        reset = 1'b0;
        step();
        chk("rst_ready", 64'(m32.ReadyE), 64'd1);
        chk("rst_busy", 64'(m32.BusyE), 64'd0);
        chk("rst_done", 64'(m32.DoneE), 64'd0);
        chk("rst_result", 64'(m32.ResultE), 64'd0);
        chk("rst_flags", 64'(m32.MulDivFlags), 64'd0);
        chk("rst_ready8", 64'(m8.ReadyE), 64'd1);

        // Each issue after the first lands in the DONE cycle: back-to-back.
        foreach (dir[i]) begin
            issue(dir[i].op, dir[i].a, dir[i].b, dir[i].r, 1'b1);
            wait_done();
        end

        issue(3'd0, 32'd9, 32'd7, 32'd63, 1'b1);
        repeat (4) step();
        chk("busy_calc", 64'(m32.BusyE), 64'd1);
        chk("ready_calc", 64'(m32.ReadyE), 64'd0);
        m32.StartE = 1'b1; m32.MulDivOpE = 3'd0; m32.Op1E = 32'd2; m32.Op2E = 32'd2;
        repeat (3) step();
        m32.StartE = 1'b0;
        wait_done();
        step();
        repeat (LAT + 6) step();
        chk("idle_after_busy", 64'(m32.BusyE), 64'd0);

        issue(3'd5, $urandom, 32'd3, 32'd0, 1'b0);
        repeat (9) step();
        m32.FlushE = 1'b1;
        step();
        m32.FlushE = 1'b0;
        chk("flush_ready", 64'(m32.ReadyE), 64'd1);
        chk("flush_busy", 64'(m32.BusyE), 64'd0);
        chk("flush_result", 64'(m32.ResultE), 64'(last_res));
        repeat (LAT + 6) step();
        chk("flush_hold", 64'(m32.ResultE), 64'(last_res));

        m32.FlushE = 1'b1; m32.StartE = 1'b1;
        m32.MulDivOpE = 3'd0; m32.Op1E = 32'd4; m32.Op2E = 32'd4;
        step();
        m32.FlushE = 1'b0; m32.StartE = 1'b0;
        chk("flush_beats_start", 64'(m32.BusyE), 64'd0);
        repeat (LAT + 6) step();

        issue(3'd0, 32'd3, 32'd5, 32'd15, 1'b1);
        wait_done();

        issue(3'd6, $urandom, 32'd11, 32'd0, 1'b0);
        repeat (19) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        last_res = '0;
        chk("rstmid_ready", 64'(m32.ReadyE), 64'd1);
        chk("rstmid_result", 64'(m32.ResultE), 64'd0);
        chk("rstmid_flags", 64'(m32.MulDivFlags), 64'd0);
        repeat (LAT + 6) step();
        chk("rstmid_hold", 64'(m32.ResultE), 64'd0);
        issue(3'd0, 32'd3, 32'd5, 32'd15, 1'b1);
        wait_done();

        repeat (300) begin
            op = 3'($urandom_range(0, 7));
            a  = pick();
            b  = pick();
            issue(op, a, b, ref32(op, a, b), 1'b1);
            wait_done();
        end
        step();

        run8(3'd5, 8'd200, 8'd7, 8'd28);
        run8(3'd0, 8'd13, 8'd11, 8'h8F);
        run8(3'd4, 8'h80, 8'hFF, 8'h80);
        run8(3'd6, 8'h80, 8'hFF, 8'h00);
        run8(3'd7, 8'h12, 8'h00, 8'h12);

        repeat (4) step();
        chk("scoreboard_empty", 64'(sbq.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
- Iterative multiply/divide unit in the execute stage, running beside the combinational ALU.
- Covers RISC-V M-extension ops and ARM MUL/UMULL-style high products; generalised in operand width.
- Radix-2, one bit per cycle, fixed latency, start/done handshake.
- Stalls the pipeline via BusyE; result is muxed onto the execute result bus when DoneE pulses.

Parameters:
- WIDTH, 32, operand/result width in bits (even, >= 4).
- LATENCY, WIDTH+2, derived (localparam): cycles from accept edge to DoneE; not overridable.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- StartE  in  1  request valid; accepted when StartE && ReadyE at a rising edge.
- FlushE  in  1  synchronous kill of any in-flight op.
- MulDivOpE  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- Op1E  in  WIDTH  operand a (multiplicand/dividend).
- Op2E  in  WIDTH  operand b (multiplier/divisor).
- ReadyE  out  1  unit can accept a request this cycle.
- BusyE  out  1  op in flight, not yet done; drives stall.
- DoneE  out  1  one-cycle pulse: ResultE valid.
- ResultE  out  WIDTH  result, held until next DoneE.
- MulDivFlags  out  2  {neg, zero} of ResultE (ARM), valid with DoneE and held.

Behaviour:
- Reset: state IDLE; ReadyE=1, BusyE=0, DoneE=0, ResultE=0, MulDivFlags=0, iteration counter=0.
- FSM states:
  - IDLE: ReadyE=1.
  - CALC: WIDTH cycles, counter WIDTH-1 down to 0.
  - FIX: 1 cycle of sign correction and result select.
  - DONE: 1 cycle, DoneE=1, ReadyE=1.
- Transitions:
  - IDLE/DONE -> CALC on accept.
  - DONE -> IDLE with no accept.
  - CALC -> FIX when counter==0.
  - FIX -> DONE.
- Accept:
  - Latches op, operand magnitudes and result-sign bits.
  - Signed ops (MULH, DIV, REM, and a for MULHSU) use absolute values.
  - Most-negative magnitude is 2^(WIDTH-1), held unsigned in WIDTH bits.
- Latency:
  - Accept at edge k gives DoneE high in cycle k+LATENCY.
  - Same latency for all ops and all operand values, including special cases.
- Back-to-back: accept during the DONE cycle is legal; the next DoneE follows LATENCY cycles later with no gap cycle.
- BusyE: 1 in CALC and FIX; 0 in IDLE and DONE.
- Multiply:
  - Shift-add into a 2*WIDTH product register.
  - FIX negates the product if the result sign is 1.
  - MUL returns the low WIDTH bits; MULH/MULHSU/MULHU return the high WIDTH bits.
- Divide:
  - Restoring algorithm producing a WIDTH-bit quotient and remainder.
  - Quotient sign = sign(a) xor sign(b); remainder sign = sign(a).
- Divide by zero (b==0):
  - DIV/DIVU return all ones.
  - REM/REMU return a unchanged.
  - Detected at accept, applied in FIX; latency unchanged.
- Signed overflow (a = most-negative, b = -1):
  - DIV returns most-negative.
  - REM returns 0.
- MulDivFlags: neg = ResultE[WIDTH-1], zero = (ResultE==0), registered together with ResultE.
- FlushE:
  - Any state goes to IDLE at the next edge.
  - No DoneE is produced and ResultE keeps its previous value.
  - FlushE dominates StartE in the same cycle: nothing is accepted.
- Reset mid-operation: same as reset; the pending result is discarded.
- StartE while BusyE=1 is ignored; no request queueing.
- Op/operand inputs are don't-care except at the accept edge.

Test Plan:
- WIDTH=32, MUL 0x0000_1234 * 0x0000_5678 -> ResultE=0x0626_0060, DoneE exactly 34 cycles after accept, flags {0,0}.
- MULH 0xFFFF_FFFF(-1) * 0x0000_0002 -> 0xFFFF_FFFF.
  - MULHU on the same operands -> 0x0000_0001.
  - MULHSU on the same operands -> 0xFFFF_FFFF.
- Signed division with a=-7, b=2:
  - DIV -> 0xFFFF_FFFD (-3).
  - REM -> 0xFFFF_FFFF (-1), flags {1,0}.
  - DIVU 7/2 -> 3.
  - REMU 7/2 -> 1.
- Special cases:
  - DIV x/0 with x=0x1234 -> 0xFFFF_FFFF.
  - REMU 0x1234 % 0 -> 0x1234.
  - DIV 0x8000_0000 / -1 -> 0x8000_0000.
  - REM 0x8000_0000 % -1 -> 0, flags {0,1}.
  - All four complete in 34 cycles.
- Back-to-back and busy handling:
  - Second StartE in the DONE cycle -> two DoneE pulses 34 cycles apart.
  - StartE while BusyE=1 -> ignored, with no extra DoneE.
- FlushE at CALC cycle 10, and reset at CALC cycle 20 (separate runs) -> no DoneE.
  - ReadyE=1 next cycle and ResultE unchanged (0 after reset).
  - A following MUL 3*5 returns 15.
  - Repeat with WIDTH=8: DIVU 200/7 -> 28, latency 10.
